// File: rtl/reg_cmd_if.sv
// reg_cmd_if: command RX, register file and response TX signals of reg_cmd_ctrl
interface reg_cmd_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdData_Valid;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  TX_Ready;
  logic                  Busy;
  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_Ready,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Busy
  );
  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_Ready,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Busy
  );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: decodes 0xAA write / 0xBB read command frames into register accesses and returns read data.
// Define WR_ACK_EN to answer every write with an 0xAC acknowledge byte.
module reg_cmd_ctrl #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    TIMEOUT    = 15,
  parameter logic [DATA_WIDTH-1:0] ERR_CODE   = 8'hEE
) (
  input logic       clk,
  input logic       rst,
  reg_cmd_if.master b
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] CMD_WR = 'hAA;
  localparam logic [DATA_WIDTH-1:0] CMD_RD = 'hBB;
`ifdef WR_ACK_EN
  localparam logic [DATA_WIDTH-1:0] WR_ACK = 'hAC;
`endif
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_PULSE, RD_ADDR, RD_WAIT, TX_SEND} state_t;
  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, tx_d;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = b.Address;
    wdata_d = b.WrData;
    tx_d    = b.TX_P_DATA;
    case (state)
      IDLE:
        if (b.RX_D_VLD)
          state_d = b.RX_P_DATA == CMD_WR ? WR_ADDR : b.RX_P_DATA == CMD_RD ? RD_ADDR : IDLE;
      WR_ADDR:
        if (b.RX_D_VLD) begin
          addr_d  = b.RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      WR_DATA:
        if (b.RX_D_VLD) begin
          wdata_d = b.RX_P_DATA;
          state_d = WR_PULSE;
        end
      WR_PULSE: begin
`ifdef WR_ACK_EN
        tx_d    = WR_ACK;
        state_d = TX_SEND;
`else
        state_d = IDLE;
`endif
      end
      RD_ADDR:
        if (b.RX_D_VLD) begin
          addr_d  = b.RX_P_DATA[ADDR_WIDTH-1:0];
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      RD_WAIT:
        if (b.RdData_Valid) begin
          tx_d    = b.RdData;
          state_d = TX_SEND;
        end else begin
          // RdEn stays high for TIMEOUT cycles; a valid in the last one still wins
          cnt_d = cnt + 1'b1;
          if (cnt == CW'(TIMEOUT - 1)) begin
            tx_d    = ERR_CODE;
            state_d = TX_SEND;
          end
        end
      TX_SEND:
        if (b.TX_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      b.Address   <= '0;
      b.WrData    <= '0;
      b.TX_P_DATA <= '0;
      b.WrEn      <= 1'b0;
      b.RdEn      <= 1'b0;
      b.TX_D_VLD  <= 1'b0;
      b.Busy      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      b.Address   <= addr_d;
      b.WrData    <= wdata_d;
      b.TX_P_DATA <= tx_d;
      b.WrEn      <= state_d == WR_PULSE;
      b.RdEn      <= state_d == RD_WAIT;
      b.TX_D_VLD  <= state_d == TX_SEND;
      b.Busy      <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl: frame-level reference model with per-cycle compare, directed boundary cases and random traffic.
module tb_reg_cmd_ctrl;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat_force = -1;
  int   rd_force = -1;
  int   rdy_force = 0;
  reg_cmd_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) b ();
  reg_cmd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(TIMEOUT), .ERR_CODE(8'hEE)) dut (
    .clk(clk),
    .rst(rst),
    .b  (b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      if (n_fail < 30) $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic send(input logic [7:0] v);
    b.RX_D_VLD  = 1'b1;
    b.RX_P_DATA = v;
    tick();
    b.RX_D_VLD  = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (b.Busy && k < 200) begin
      tick();
      k++;
    end
    chk("idle_wait", 32'(b.Busy), 0);
  endtask
  // Register file / transmitter stand-in, driven 1 time unit after each edge
  int rcnt = 0;
  int lat = 1;
  always @(posedge clk) begin
    #1;
    if (!b.RdEn) begin
      rcnt = 0;
      b.RdData_Valid = 1'b0;
      lat = lat_force >= 0 ? lat_force : int'($urandom_range(0, 18));
    end else begin
      b.RdData_Valid = rcnt == lat;
      rcnt++;
    end
    b.RdData = rd_force >= 0 ? 8'(rd_force) : 8'($urandom);
    b.TX_Ready = rdy_force == 1 ? 1'b1 : rdy_force == 2 ? 1'b0 : 1'($urandom_range(0, 1));
  end
  // Reference model: collected frame bytes plus pending write pulse, read age and response
  logic [7:0] fr[$];
  bit         m_wr, m_resp;
  int         m_age;
  logic [7:0] m_tx, m_wd;
  logic [3:0] m_ad;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fr.delete();
      m_wr = 0;
      m_resp = 0;
      m_age = -1;
      m_tx = 0;
      m_wd = 0;
      m_ad = 0;
    end else if (m_resp) begin
      if (b.TX_Ready) m_resp = 0;
    end else if (m_age >= 0) begin
      if (b.RdData_Valid) begin
        m_tx = b.RdData;
        m_resp = 1;
        m_age = -1;
      end else if (m_age + 1 == TIMEOUT) begin
        m_tx = 8'hEE;
        m_resp = 1;
        m_age = -1;
      end else m_age++;
    end else if (m_wr) begin
      m_wr = 0;
`ifdef WR_ACK_EN
      m_tx = 8'hAC;
      m_resp = 1;
`endif
    end else if (b.RX_D_VLD) begin
      fr.push_back(b.RX_P_DATA);
      if (fr[0] != 8'hAA && fr[0] != 8'hBB) fr.delete();
      else if (fr.size() == 2) begin
        m_ad = fr[1][3:0];
        if (fr[0] == 8'hBB) begin
          m_age = 0;
          fr.delete();
        end
      end else if (fr.size() == 3) begin
        m_wd = fr[2];
        m_wr = 1;
        fr.delete();
      end
    end
  end
  always @(negedge clk) begin
    chk("WrEn", 32'(b.WrEn), 32'(m_wr));
    chk("RdEn", 32'(b.RdEn), 32'(m_age >= 0));
    chk("TX_D_VLD", 32'(b.TX_D_VLD), 32'(m_resp));
    chk("Busy", 32'(b.Busy), 32'(fr.size() != 0 || m_wr || m_age >= 0 || m_resp));
    chk("Address", 32'(b.Address), 32'(m_ad));
    chk("WrData", 32'(b.WrData), 32'(m_wd));
    chk("TX_P_DATA", 32'(b.TX_P_DATA), 32'(m_tx));
    chk("WrEn_RdEn_excl", 32'(b.WrEn & b.RdEn), 0);
  end
  initial begin
    int hi, k, st;
    rst = 1'b0;
    b.RX_D_VLD = 1'b0;
    b.RX_P_DATA = 8'h00;
    rdy_force = 1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_Busy", 32'(b.Busy), 0);
    chk("rst_TX_D_VLD", 32'(b.TX_D_VLD), 0);
    chk("rst_Address", 32'(b.Address), 0);
    tick();
    rst = 1'b1;
    tick();
    // write frame
    send(8'hAA); send(8'h05); send(8'h3C);
    @(negedge clk);
    chk("wr_WrEn", 32'(b.WrEn), 1);
    chk("wr_Address", 32'(b.Address), 5);
    chk("wr_WrData", 32'(b.WrData), 32'h3C);
    chk("wr_RdEn", 32'(b.RdEn), 0);
    tick();
    @(negedge clk);
    chk("wr_pulse_end", 32'(b.WrEn), 0);
`ifndef WR_ACK_EN
    chk("wr_Busy_clear", 32'(b.Busy), 0);
`endif
    // nominal read
    wait_idle();
    lat_force = 1;
    rd_force = 8'h81;
    send(8'hBB); send(8'h02);
    @(negedge clk);
    chk("rd_RdEn", 32'(b.RdEn), 1);
    chk("rd_Address", 32'(b.Address), 2);
    tick();
    @(negedge clk);
    chk("rd_early_vld", 32'(b.TX_D_VLD), 0);
    tick();
    @(negedge clk);
    chk("rd_TX_D_VLD", 32'(b.TX_D_VLD), 1);
    chk("rd_TX_P_DATA", 32'(b.TX_P_DATA), 32'h81);
    chk("rd_RdEn_drop", 32'(b.RdEn), 0);
    tick();
    @(negedge clk);
    chk("rd_accepted", 32'(b.TX_D_VLD), 0);
    chk("rd_Busy_clear", 32'(b.Busy), 0);
    // timeout, then valid arriving in the final wait cycle
    for (int t = 0; t < 2; t++) begin
      wait_idle();
      lat_force = t == 0 ? 99 : 14;
      rd_force = 8'h5A;
      send(8'hBB); send(t == 0 ? 8'h07 : 8'h01);
      hi = 0;
      k = 0;
      while (k < 40) begin
        @(negedge clk);
        if (b.RdEn) hi++;
        if (b.TX_D_VLD) break;
        tick();
        k++;
      end
      chk("to_RdEn_cycles", 32'(hi), 15);
      chk("to_TX_D_VLD", 32'(b.TX_D_VLD), 1);
      chk("to_TX_P_DATA", 32'(b.TX_P_DATA), t == 0 ? 32'hEE : 32'h5A);
      tick();
    end
    // illegal lead byte then write
    wait_idle();
    send(8'h55); send(8'hAA); send(8'h03); send(8'h11);
    @(negedge clk);
    chk("ill_WrEn", 32'(b.WrEn), 1);
    chk("ill_Address", 32'(b.Address), 3);
    chk("ill_WrData", 32'(b.WrData), 32'h11);
    // backpressure with a byte arriving during TX_SEND
    wait_idle();
    rdy_force = 2;
    lat_force = 1;
    rd_force = 8'hC3;
    send(8'hBB); send(8'h09);
    tick();
    tick();
    st = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b.TX_D_VLD && b.TX_P_DATA == 8'hC3) st++;
      tick();
      b.RX_D_VLD = i == 3;
      b.RX_P_DATA = 8'hAA;
      if (i == 8) rdy_force = 1;
    end
    b.RX_D_VLD = 1'b0;
    chk("bp_stable_cycles", 32'(st), 10);
    @(negedge clk);
    chk("bp_11th_vld", 32'(b.TX_D_VLD), 1);
    tick();
    @(negedge clk);
    chk("bp_accepted", 32'(b.TX_D_VLD), 0);
    chk("bp_overrun_dropped", 32'(b.Busy), 0);
    // reset while waiting for read data
    lat_force = 99;
    send(8'hBB); send(8'h04);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_RdEn", 32'(b.RdEn), 0);
    chk("mid_rst_TX_D_VLD", 32'(b.TX_D_VLD), 0);
    chk("mid_rst_Busy", 32'(b.Busy), 0);
    tick();
    rst = 1'b1;
    send(8'hAA); send(8'h0A); send(8'h77);
    @(negedge clk);
    chk("post_rst_WrEn", 32'(b.WrEn), 1);
    chk("post_rst_Address", 32'(b.Address), 32'hA);
    chk("post_rst_WrData", 32'(b.WrData), 32'h77);
    // random traffic
    lat_force = -1;
    rd_force = -1;
    rdy_force = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      tick();
      r = int'($urandom_range(0, 9));
      b.RX_D_VLD = $urandom_range(0, 2) == 0;
      b.RX_P_DATA = r < 3 ? 8'hAA : r < 6 ? 8'hBB : 8'($urandom);
      rst = !(i >= 2000 && i < 2002);
    end
    b.RX_D_VLD = 1'b0;
    rdy_force = 1;
    repeat (40) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
